// File: rtl/lcd_port_arbiter.sv
// Round-robin arbiter sharing one character-LCD write channel among three requesters,
// with burst lock, level-held lcd_start handshake and a watchdog abort.
module lcd_port_arbiter #(
    parameter int TIMEOUT   = 50000,
    parameter int MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [2:0] rs_in,
    output logic [2:0] grant,
    output logic [2:0] ack,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_start,
    input  logic       lcd_done,
    output logic       err_timeout,
    output logic       busy
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_DONE = 2'd1;
    localparam logic [1:0] S_DRAIN     = 2'd2;

    localparam int            TW         = 21;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    BURST_LAST = 8'(MAX_BURST - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]    owner_q, owner_d;
    logic [7:0]    burst_cnt_q, burst_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    ack_q, ack_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_start_q, lcd_start_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [1:0]    win_s;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        wrap_inc = (p == 2'd2) ? 2'd0 : (p + 2'd1);
    endfunction

    // Search starts just after the last owner, so the last owner has lowest priority.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = wrap_inc(ptr);
        c2 = wrap_inc(c1);
        if (r[c1]) begin
            rr_pick = c1;
        end else if (r[c2]) begin
            rr_pick = c2;
        end else begin
            rr_pick = ptr;
        end
    endfunction

    function automatic logic [7:0] pick_byte(input logic [1:0] w, input logic [7:0] d0,
                                             input logic [7:0] d1, input logic [7:0] d2);
        case (w)
            2'd0:    pick_byte = d0;
            2'd1:    pick_byte = d1;
            default: pick_byte = d2;
        endcase
    endfunction

    assign win_s = rr_pick(req, rr_ptr_q);

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        timer_d     = timer_q;
        grant_d     = grant_q;
        ack_d       = 3'b000;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_start_d = lcd_start_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    owner_d     = win_s;
                    lcd_data_d  = pick_byte(win_s, data0, data1, data2);
                    lcd_rs_d    = rs_in[win_s];
                    grant_d     = 3'b001 << win_s;
                    lcd_start_d = 1'b1;
                    timer_d     = 21'd0;
                    burst_cnt_d = 8'd0;
                    state_d     = S_WAIT_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_q + 21'd1;
                // Completion takes precedence over a coincident watchdog expiry.
                if (lcd_done) begin
                    lcd_start_d = 1'b0;
                    ack_d       = 3'b001 << owner_q;
                    state_d     = S_DRAIN;
                end else if (timer_q == TIMER_LAST) begin
                    lcd_start_d = 1'b0;
                    err_d       = 1'b1;
                    grant_d     = 3'b000;
                    rr_ptr_d    = owner_q;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_DRAIN: begin
                // Hold here until a level-type done is released.
                if (lcd_done) begin
                    state_d = S_DRAIN;
                end else if (lock[owner_q] && req[owner_q] && (burst_cnt_q < BURST_LAST)) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    lcd_data_d  = pick_byte(owner_q, data0, data1, data2);
                    lcd_rs_d    = rs_in[owner_q];
                    lcd_start_d = 1'b1;
                    timer_d     = 21'd0;
                    state_d     = S_WAIT_DONE;
                end else begin
                    grant_d  = 3'b000;
                    rr_ptr_d = owner_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                grant_d     = 3'b000;
                lcd_start_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 2'd2;
            owner_q     <= 2'd0;
            burst_cnt_q <= 8'd0;
            timer_q     <= 21'd0;
            grant_q     <= 3'b000;
            ack_q       <= 3'b000;
            lcd_data_q  <= 8'd0;
            lcd_rs_q    <= 1'b0;
            lcd_start_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_start_q <= lcd_start_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign lcd_data    = lcd_data_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_start   = lcd_start_q;
    assign err_timeout = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Bench for lcd_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_lcd_port_arbiter;

    localparam int TIMEOUT   = 8;
    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req, lock, rs_in;
    logic [7:0] data0, data1, data2;
    logic [2:0] grant, ack;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_start, lcd_done, err_timeout, busy;

    lcd_port_arbiter #(.TIMEOUT(TIMEOUT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .data0(data0), .data1(data1), .data2(data2), .rs_in(rs_in),
        .grant(grant), .ack(ack), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_start(lcd_start), .lcd_done(lcd_done),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the channel and what it is doing, in plain integers.
    int         m_busy_with;   // -1 when nobody owns the channel
    bit         m_draining;
    int         m_last_owner;
    int         m_bytes_in_burst;
    int         m_cycles_waited;
    logic [2:0] e_grant, e_ack;
    logic [7:0] e_data;
    logic       e_rs, e_start, e_err, e_busy;

    // Completion driver knobs.
    int wait_cnt, hold_left, d_delay, d_hold;
    bit auto_mode;

    // Scenario scratch.
    int         acks, cnt_a, cnt_b, flag;
    logic [2:0] seq [4];
    logic [2:0] prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input int w);
        return (w == 0) ? data0 : (w == 1) ? data1 : data2;
    endfunction

    task automatic begin_byte();
        e_data          = byte_of(m_busy_with);
        e_rs            = rs_in[m_busy_with];
        e_grant         = 3'b001 << m_busy_with;
        e_start         = 1'b1;
        m_cycles_waited = 0;
        m_draining      = 1'b0;
    endtask

    task automatic release_channel();
        m_last_owner = m_busy_with;
        m_busy_with  = -1;
        e_grant      = 3'b000;
    endtask

    task automatic model_step();
        bit found;
        e_ack = 3'b000;
        e_err = 1'b0;
        if (!rst) begin
            m_busy_with = -1; m_draining = 1'b0; m_last_owner = 2;
            m_bytes_in_burst = 0; m_cycles_waited = 0;
            e_grant = 3'b000; e_data = 8'h00; e_rs = 1'b0; e_start = 1'b0;
        end else if (m_busy_with < 0) begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (!found && req[(m_last_owner + k) % 3]) begin
                    found = 1'b1;
                    m_busy_with = (m_last_owner + k) % 3;
                end
            end
            if (found) begin
                m_bytes_in_burst = 1;
                begin_byte();
            end
        end else if (!m_draining) begin
            if (lcd_done) begin
                e_start    = 1'b0;
                e_ack      = 3'b001 << m_busy_with;
                m_draining = 1'b1;
            end else if (m_cycles_waited + 1 == TIMEOUT) begin
                e_start = 1'b0;
                e_err   = 1'b1;
                release_channel();
            end else begin
                m_cycles_waited++;
            end
        end else if (!lcd_done) begin
            if (lock[m_busy_with] && req[m_busy_with] && m_bytes_in_burst < MAX_BURST) begin
                m_bytes_in_burst++;
                begin_byte();
            end else begin
                release_channel();
            end
        end
        e_busy = (m_busy_with >= 0);
    endtask

    task automatic compare();
        check("grant", grant, e_grant);
        check("ack", ack, e_ack);
        check("lcd_start", lcd_start, e_start);
        check("err_timeout", err_timeout, e_err);
        check("busy", busy, e_busy);
        if (e_busy) begin
            check("lcd_data", lcd_data, e_data);
            check("lcd_rs", lcd_rs, e_rs);
        end
    endtask

    task automatic rearm();
        if ($urandom_range(0, 5) == 0) d_delay = $urandom_range(TIMEOUT, TIMEOUT + 4);
        else d_delay = $urandom_range(0, TIMEOUT - 2);
        d_hold = $urandom_range(1, 4);
    endtask

    // LCD driver stand-in: raise lcd_done d_delay cycles into a write, held d_hold cycles.
    task automatic drive_done();
        if (hold_left > 0) begin
            lcd_done = 1'b1;
            hold_left--;
        end else if (lcd_start) begin
            if (wait_cnt >= d_delay) begin
                lcd_done  = 1'b1;
                hold_left = d_hold - 1;
                wait_cnt  = 0;
                if (auto_mode) rearm();
            end else begin
                lcd_done = 1'b0;
                wait_cnt++;
            end
        end else begin
            lcd_done = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive_done();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b0; req = 3'b000; lock = 3'b000;
        wait_cnt = 0; hold_left = 0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic random_inputs();
        rst = ($urandom_range(0, 299) != 0);
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 9) == 0) lock[i] = ~lock[i];
        end
        data0 = 8'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
        rs_in = 3'($urandom);
    endtask

    initial begin
        rst = 1'b0; req = 3'b000; lock = 3'b000; rs_in = 3'b000;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00; lcd_done = 1'b0;
        auto_mode = 1'b0; d_delay = 4; d_hold = 1; wait_cnt = 0; hold_left = 0;

        // Single byte from requester 0.
        do_reset();
        check("reset_grant", grant, 3'b000);
        check("reset_start", lcd_start, 1'b0);
        check("reset_busy", busy, 1'b0);
        d_delay = 4; d_hold = 1;
        data0 = 8'h41; data1 = 8'h52; data2 = 8'h63; rs_in = 3'b001; req = 3'b001;
        step();
        check("t1_start", lcd_start, 1'b1);
        check("t1_data", lcd_data, 8'h41);
        check("t1_rs", lcd_rs, 1'b1);
        check("t1_grant", grant, 3'b001);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack == 3'b001) begin acks++; req = 3'b000; end
        end
        check("t1_ack_count", acks, 32'd1);
        check("t1_idle", busy, 1'b0);

        // Fair rotation with all three requesting and no lock.
        do_reset();
        req = 3'b111; lock = 3'b000; d_delay = 2; d_hold = 1;
        for (int i = 0; i < 4; i++) seq[i] = 3'b000;
        cnt_a = 0; prev = 3'b000;
        for (int i = 0; i < 100; i++) begin
            step();
            if (grant != 3'b000 && prev == 3'b000 && cnt_a < 4) begin
                seq[cnt_a] = grant;
                cnt_a++;
            end
            prev = grant;
        end
        check("t2_grant0", seq[0], 3'b001);
        check("t2_grant1", seq[1], 3'b010);
        check("t2_grant2", seq[2], 3'b100);
        check("t2_grant3", seq[3], 3'b001);

        // Locked burst capped at MAX_BURST bytes.
        do_reset();
        req = 3'b011; lock = 3'b001; d_delay = 1; d_hold = 1;
        cnt_a = 0; cnt_b = 0; flag = 0;
        for (int i = 0; i < 200 && flag == 0; i++) begin
            step();
            if (ack == 3'b001) cnt_a++;
            if (grant == 3'b010) flag = 1;
            if (cnt_a >= 1 && cnt_a < 4 && grant == 3'b000) cnt_b++;
        end
        check("t3_burst_acks", cnt_a, 32'd4);
        check("t3_grant_held", cnt_b, 32'd0);
        check("t3_then_req1", flag, 32'd1);
        req = 3'b000; lock = 3'b000;
        for (int i = 0; i < 20; i++) step();

        // Watchdog abort, then the other requester is served.
        do_reset();
        req = 3'b011; d_delay = 1000; d_hold = 1;
        cnt_a = 0; cnt_b = 0; acks = 0; flag = 0;
        for (int i = 0; i < 100 && flag == 0; i++) begin
            step();
            if (lcd_start && grant == 3'b001) cnt_a++;
            if (err_timeout) cnt_b++;
            if (ack != 3'b000) acks++;
            if (grant == 3'b010) flag = 1;
        end
        check("t4_start_cycles", cnt_a, 32'd8);
        check("t4_err_pulses", cnt_b, 32'd1);
        check("t4_no_ack", acks, 32'd0);
        check("t4_next_owner", flag, 32'd1);
        d_delay = 1; req = 3'b000;
        for (int i = 0; i < 20; i++) step();

        // Level-type done held after completion: one ack, burst waits for release.
        do_reset();
        req = 3'b001; lock = 3'b001; d_delay = 1; d_hold = 7;
        acks = 0; cnt_a = 0; flag = 0;
        for (int i = 0; i < 40 && flag == 0; i++) begin
            step();
            if (ack != 3'b000) begin
                acks++;
                d_hold = 1;
            end else if (acks > 0) begin
                if (lcd_start) flag = 1;
                else cnt_a++;
            end
        end
        check("t5_single_ack", acks, 32'd1);
        check("t5_drain_cycles", cnt_a, 32'd6);
        check("t5_restart", flag, 32'd1);
        req = 3'b000; lock = 3'b000;
        for (int i = 0; i < 20; i++) step();

        // Reset in the middle of a transfer.
        do_reset();
        req = 3'b010; d_delay = 1000; d_hold = 1;
        step(); step(); step();
        check("t6_owner", grant, 3'b010);
        rst = 1'b0;
        step();
        check("t6_start", lcd_start, 1'b0);
        check("t6_grant", grant, 3'b000);
        check("t6_ack", ack, 3'b000);
        rst = 1'b1; req = 3'b101; d_delay = 2;
        step();
        check("t6_prio", grant, 3'b001);
        req = 3'b000;
        for (int i = 0; i < 20; i++) step();

        // Randomized traffic.
        auto_mode = 1'b1;
        rearm();
        for (int i = 0; i < 4000; i++) begin
            random_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
